// File: rtl/sensor_arbiter.sv
// sensor_arbiter: round-robin scheduler handing one parser word at a time to a valid/ready consumer.
// Optional macro SENSOR_ARBITER_SEQ_EN builds the out_seq delivery counter; otherwise out_seq is 0.
`timescale 1ns/1ps
module sensor_arbiter #(
    parameter int NUM_SENSORS     = 4,
    parameter int SENSOR_IDX_W    = 2,
    parameter int RELEASE_TIMEOUT = 255
) (
    input  logic                         clk_72MHz,
    input  logic                         reset,
    input  logic [102*NUM_SENSORS-1:0]   sensor_iterations_in,
    input  logic [NUM_SENSORS-1:0]       sensor_data_avl,
    output logic [NUM_SENSORS-1:0]       reset_parser,
    output logic [101:0]                 out_data,
    output logic [SENSOR_IDX_W-1:0]      out_sensor_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_seq,
    output logic                         busy,
    output logic                         release_timeout_err
);
    localparam int CNT_W = $clog2(RELEASE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t                  state_q, state_d;
    logic [SENSOR_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_SENSORS-1:0]  reset_parser_q, reset_parser_d;
    logic [101:0]            out_data_q, out_data_d;
    logic [SENSOR_IDX_W-1:0] idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    found;
    logic [SENSOR_IDX_W-1:0] win;
    logic [101:0]            win_word;
    logic [SENSOR_IDX_W-1:0] win_next;
    logic [NUM_SENSORS-1:0]  grant_oh;
    logic                    handshake;
    logic                    avl_k;

    assign handshake = valid_q & out_ready;
    // reset_parser_q is one-hot on the granted sensor while releasing, so it doubles as the avl mask.
    assign avl_k     = |(sensor_data_avl & reset_parser_q);

    // Two passes give "first set bit at or after rr_ptr, then wrap" without a variable modulo.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_word = '0;
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (!found && sensor_data_avl[j] && (j >= int'(rr_ptr_q))) begin
                found    = 1'b1;
                win      = SENSOR_IDX_W'(j);
                win_word = sensor_iterations_in[102*j +: 102];
            end
        end
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (!found && sensor_data_avl[j] && (j < int'(rr_ptr_q))) begin
                found    = 1'b1;
                win      = SENSOR_IDX_W'(j);
                win_word = sensor_iterations_in[102*j +: 102];
            end
        end
        win_next = (int'(win) == NUM_SENSORS - 1) ? '0 : win + 1'b1;
        for (int j = 0; j < NUM_SENSORS; j++) begin
            grant_oh[j] = (int'(idx_q) == j);
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        reset_parser_d = reset_parser_q;
        out_data_d     = out_data_q;
        idx_d          = idx_q;
        valid_d        = valid_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    out_data_d = win_word;
                    idx_d      = win;
                    valid_d    = 1'b1;
                    rr_ptr_d   = win_next;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    valid_d        = 1'b0;
                    reset_parser_d = grant_oh;
                    cnt_d          = '0;
                    state_d        = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                if (!avl_k) begin
                    reset_parser_d = '0;
                    state_d        = IDLE;
                end else if (cnt_q == CNT_W'(RELEASE_TIMEOUT - 1)) begin
                    // Parser never let go: abort, flag it, and let round-robin come back to it later.
                    reset_parser_d = '0;
                    err_d          = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            reset_parser_q <= '0;
            out_data_q     <= '0;
            idx_q          <= '0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            reset_parser_q <= reset_parser_d;
            out_data_q     <= out_data_d;
            idx_q          <= idx_d;
            valid_q        <= valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end

`ifdef SENSOR_ARBITER_SEQ_EN
    logic [7:0] seq_q, seq_d;

    always_comb begin
        seq_d = handshake ? seq_q + 8'd1 : seq_q;
    end

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            seq_q <= 8'd0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign out_seq = seq_q;
`else
    assign out_seq = 8'd0;
`endif

    assign reset_parser        = reset_parser_q;
    assign out_data            = out_data_q;
    assign out_sensor_idx      = idx_q;
    assign out_valid           = valid_q;
    assign busy                = busy_q;
    assign release_timeout_err = err_q;

endmodule

// File: tb/tb_sensor_arbiter.sv
// tb_sensor_arbiter: randomized parser models feeding sensor_arbiter, scoreboard against a round-robin set model.
`timescale 1ns/1ps
module tb_sensor_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int DW = 102;
  localparam int EW = 8 + IW + DW;

  // ---------------- clock / reset ----------------
  logic clk_72MHz = 1'b0;
  always #7 clk_72MHz = ~clk_72MHz;

  logic             reset;
  logic [DW*N-1:0]  sensor_iterations_in;
  logic [N-1:0]     sensor_data_avl;
  logic [N-1:0]     reset_parser;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_sensor_idx;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_seq;
  logic             busy;
  logic             release_timeout_err;

  sensor_arbiter #(
    .NUM_SENSORS(N),
    .SENSOR_IDX_W(IW),
    .RELEASE_TIMEOUT(TO)
  ) dut (
    .clk_72MHz(clk_72MHz),
    .reset(reset),
    .sensor_iterations_in(sensor_iterations_in),
    .sensor_data_avl(sensor_data_avl),
    .reset_parser(reset_parser),
    .out_data(out_data),
    .out_sensor_idx(out_sensor_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_seq(out_seq),
    .busy(busy),
    .release_timeout_err(release_timeout_err)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int ready_mode = 0;             // 0 random, 1 held low, 2 held high
  int m_ptr = 0;
  int m_seq = 0;
  logic [DW-1:0] words[N];
  int delay[N];
  bit stuck[N];
  int raised[N]  = '{default: 0};
  int dropped[N] = '{default: 0};
  int pcnt[N]    = '{default: 0};
  bit to_seen[N] = '{default: 0};

  for (genvar g = 0; g < N; g++) begin : g_avl
    assign sensor_data_avl[g] = (raised[g] != dropped[g]);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: deliveries for a batch of pending sensors under round-robin; a stuck sensor is served twice.
  task automatic model_batch(input logic [N-1:0] pend_in, input logic [N-1:0] stk_in);
    logic [N-1:0] pend;
    logic [N-1:0] stk;
    logic [7:0]   sq;
    int           w;
    pend = pend_in;
    stk  = stk_in;
    while (pend != '0) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (w < 0 && pend[c]) w = c;
      end
`ifdef SENSOR_ARBITER_SEQ_EN
      sq = 8'(m_seq);
`else
      sq = 8'd0;
`endif
      exp_q.push_back({sq, IW'(w), words[w]});
      m_seq++;
      if (stk[w]) stk[w] = 1'b0;
      else pend[w] = 1'b0;
      m_ptr = (w + 1) % N;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic raise(input logic [N-1:0] mask, input logic [N-1:0] stk,
                       input logic [DW-1:0] fixed, input bit use_fixed);
    @(posedge clk_72MHz); #1;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        logic [DW-1:0] w;
        w = use_fixed ? fixed : DW'({$urandom, $urandom, $urandom, $urandom});
        words[k] = w;
        sensor_iterations_in[DW*k +: DW] = w;
        delay[k] = $urandom_range(1, 4);
        stuck[k] = stk[k];
        raised[k]++;
      end
    end
    model_batch(mask, stk);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk_72MHz);
      n++;
    end
    check("valid_arrives", out_valid, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 3000 && !(exp_q.size() == 0 && !busy && sensor_data_avl == '0)) begin
      @(negedge clk_72MHz);
      n++;
    end
    check("batch_done_in_budget", (n < 3000), 1'b1);
  endtask

  // Parser models: drop avl delay[k] cycles into reset_parser; a stuck parser ignores its first release.
  always @(posedge clk_72MHz) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (reset_parser[k]) begin
        pcnt[k]++;
        if (pcnt[k] >= delay[k] && !(stuck[k] && !to_seen[k])) begin
          dropped[k] = raised[k];
          to_seen[k] = 1'b0;
        end
      end else begin
        if (pcnt[k] > 0 && sensor_data_avl[k]) to_seen[k] = 1'b1;
        pcnt[k] = 0;
      end
    end
  end

  always @(posedge clk_72MHz) begin
    #1;
    if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = (ready_mode == 2);
  end

  // ---------------- scoreboard monitor ----------------
  logic          prev_v = 1'b0;
  logic          prev_hs = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [IW-1:0] prev_i = '0;
  int            run = 0;
  int            run_k = 0;

  always @(negedge clk_72MHz) begin
    if (reset) begin
      prev_v = 1'b0;
      run = 0;
    end else begin
      logic [EW-1:0] e;
      check("reset_parser_onehot0", ($countones(reset_parser) <= 1), 1'b1);
      check("reset_parser_outside_release", (out_valid && reset_parser != '0), 1'b0);
      if (prev_v && !prev_hs) begin
        check("valid_held", out_valid, 1'b1);
        check("data_stable", out_data, prev_d);
        check("idx_stable", out_sensor_idx, prev_i);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0d data %0h expected no delivery", out_sensor_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_sensor_idx", out_sensor_idx, e[DW+IW-1:DW]);
          check("out_data", out_data, e[DW-1:0]);
          check("out_seq", out_seq, e[EW-1:DW+IW]);
        end
      end
      prev_v  = out_valid;
      prev_hs = out_valid && out_ready;
      prev_d  = out_data;
      prev_i  = out_sensor_idx;
      if (reset_parser != '0) begin
        run++;
        for (int k = 0; k < N; k++) if (reset_parser[k]) run_k = k;
      end else if (run > 0) begin
        check("release_length", run, sensor_data_avl[run_k] ? TO : delay[run_k]);
        if (sensor_data_avl[run_k]) check("timeout_err_set", release_timeout_err, 1'b1);
        run = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] cap;
    logic [N-1:0]  mask;
    logic [N-1:0]  stk;
    int            iter;
    reset = 1'b1;
    sensor_iterations_in = '0;
    for (int k = 0; k < N; k++) begin
      delay[k] = 2;
      stuck[k] = 1'b0;
      words[k] = '0;
    end
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_reset_parser", reset_parser, '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_idx", out_sensor_idx, '0);
    check("rst_out_seq", out_seq, '0);
    check("rst_err", release_timeout_err, 1'b0);
    repeat (3) @(posedge clk_72MHz);
    #1 reset = 1'b0;
    @(negedge clk_72MHz);
    check("idle_no_request", busy, 1'b0);

    // Single request, one-cycle grant latency
    ready_mode = 2;
    raise(4'b0100, 4'b0000, DW'(102'h2A5), 1'b1);
    @(negedge clk_72MHz);
    check("no_early_valid", out_valid, 1'b0);
    @(negedge clk_72MHz);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, DW'(102'h2A5));
    check("single_idx", out_sensor_idx, 2'd2);
    @(negedge clk_72MHz);
    check("single_release_bit", reset_parser, 4'b0100);
    check("single_valid_drop", out_valid, 1'b0);
    wait_done();

    // Async reset while presenting a word
    ready_mode = 1;
    raise(4'b1000, 4'b0000, '0, 1'b0);
    wait_valid();
    @(negedge clk_72MHz);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_reset_parser", reset_parser, '0);
    exp_q.delete();
    m_ptr = 0;
    m_seq = 0;
    model_batch(sensor_data_avl, 4'b0000);
    repeat (2) @(posedge clk_72MHz);
    #1 reset = 1'b0;
    ready_mode = 0;
    wait_done();

    // Backpressure
    ready_mode = 1;
    raise(4'b0010, 4'b0000, '0, 1'b0);
    wait_valid();
    cap = out_data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_72MHz);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, cap);
      check("bp_reset_parser", reset_parser, '0);
    end
    ready_mode = 2;
    @(negedge clk_72MHz);
    check("bp_pre_handshake", reset_parser, '0);
    @(negedge clk_72MHz);
    check("bp_release_entered", reset_parser, 4'b0010);
    wait_done();

    // Full contention
    ready_mode = 0;
    raise(4'b1111, 4'b0000, '0, 1'b0);
    wait_done();

    // Release timeout on sensor 0
    check("err_before_timeout", release_timeout_err, 1'b0);
    raise(4'b0101, 4'b0001, '0, 1'b0);
    wait_done();
    check("err_after_timeout", release_timeout_err, 1'b1);

    // Random batches, long enough to wrap the sequence counter
    iter = 0;
    while (m_seq < 300 && iter < 400) begin
      mask = N'($urandom_range(1, 15));
      stk  = '0;
      if ($urandom_range(0, 4) == 0) stk = mask & N'(1 << $urandom_range(0, 3));
      raise(mask, stk, '0, 1'b0);
      wait_done();
      iter++;
    end
    check("err_sticky", release_timeout_err, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
